// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: one valid/ready register command in, one AXI4-Lite transaction out,
// one valid/ready response back. Single outstanding transaction with a sticky watchdog.
module axi_lite_cmd_master #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 12,
  parameter logic [31:0] C_BASE_ADDRESS     = 32'h00000000,
  parameter int unsigned C_TIMEOUT          = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              busy,
  output logic                              timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int unsigned DW   = C_M_AXI_DATA_WIDTH;
  localparam int unsigned AW   = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned WD_W = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LOAD  = WD_W'(C_TIMEOUT);
  localparam logic [AW-1:0]   ADDR_XOR = C_BASE_ADDRESS[AW-1:0];

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d, busy_q, busy_d;
  logic            accept, hs, wd_active;

  assign accept    = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
  assign hs        = (awvalid_q && M_AXI_AWREADY) || (wvalid_q && M_AXI_WREADY) ||
                     (bready_q && M_AXI_BVALID) || (arvalid_q && M_AXI_ARREADY) ||
                     (rready_q && M_AXI_RVALID);
  assign wd_active = (state_q == S_WRITE) || (state_q == S_WRESP) ||
                     (state_q == S_RADDR) || (state_q == S_RDATA);

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wd_d        = wd_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr ^ ADDR_XOR;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end
        end
      end
      S_WRITE: begin
        // AW and W retire independently; move on once both have handshaken
        awvalid_d = awvalid_q && !M_AXI_AWREADY;
        wvalid_d  = wvalid_q && !M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_BRESP;
          state_d     = S_RESP;
        end
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog counts down from C_TIMEOUT; the flag sets on the cycle it would reach zero
    if (accept) begin
      wd_d = WD_LOAD;
    end else if (wd_active) begin
      if (hs) begin
        wd_d = WD_LOAD;
      end else if (wd_q != '0) begin
        wd_d = wd_q - WD_W'(1);
        if (wd_q == WD_W'(1)) timeout_d = 1'b1;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign busy          = busy_q;
  assign timeout       = timeout_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: scripted cycle-by-cycle slave, response scoreboard.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, timeout;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0, rready;

  int vecs = 0;
  int errs = 0;

  typedef struct packed {
    logic        w;
    logic [31:0] d;
    logic [1:0]  r;
  } rsp_t;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  axi_lite_cmd_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(12),
    .C_BASE_ADDRESS(32'h00000000),
    .C_TIMEOUT(16)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .timeout(timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // Response scoreboard: each completed rsp handshake must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL sb_unexpected_rsp: got w=%0b d=%h r=%b, required no response", rsp_write, rsp_rdata, rsp_resp);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
          errs++;
          $display("FAIL sb_rsp: got w=%0b d=%h r=%b, required w=%0b d=%h r=%b",
                   rsp_write, rsp_rdata, rsp_resp, e.w, e.d, e.r);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vecs++;
    if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, timeout, busy} !== 9'b0) begin
      errs++;
      $display("FAIL reset_ctrl: got %b, required 000000000",
               {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, timeout, busy});
    end
    vecs++;
    if ({rsp_write, rsp_rdata, rsp_resp, awprot, arprot} !== 41'b0) begin
      errs++;
      $display("FAIL reset_rsp: got w=%0b d=%h r=%b prot=%b/%b, required all zero",
               rsp_write, rsp_rdata, rsp_resp, awprot, arprot);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    vecs++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: got cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write();
    awready = 1; wready = 1; rsp_ready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h008; cmd_wdata = 32'hA5A50001; cmd_wstrb = 4'hF;
    exp_q.push_back({1'b1, 32'h0, 2'b00});
    step();
    cmd_valid = 0;
    vecs++;
    if ({awvalid, wvalid, awaddr, wdata, wstrb, cmd_ready, busy} !== {2'b11, 12'h008, 32'hA5A50001, 4'hF, 2'b01}) begin
      errs++;
      $display("FAIL write_n1: got aw=%b w=%b addr=%h data=%h strb=%h cr=%b busy=%b, required 1 1 008 a5a50001 f 0 1",
               awvalid, wvalid, awaddr, wdata, wstrb, cmd_ready, busy);
    end
    step();
    vecs++;
    if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
      errs++;
      $display("FAIL write_n2: got aw=%b w=%b b=%b rv=%b, required 0 0 1 0", awvalid, wvalid, bready, rsp_valid);
    end
    bvalid = 1; bresp = 2'b00;
    step();
    bvalid = 0;
    vecs++;
    if ({rsp_valid, rsp_write, rsp_rdata, rsp_resp, bready} !== {2'b11, 32'h0, 2'b00, 1'b0}) begin
      errs++;
      $display("FAIL write_n3: got rv=%b w=%b d=%h r=%b bready=%b, required 1 1 00000000 00 0",
               rsp_valid, rsp_write, rsp_rdata, rsp_resp, bready);
    end
    step();
    vecs++;
    if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
      errs++;
      $display("FAIL write_n4: got cr=%b rv=%b busy=%b, required 1 0 0", cmd_ready, rsp_valid, busy);
    end
    awready = 0; wready = 0;
  endtask

  task automatic test_skewed_write();
    int aw_hs = 0;
    int w_hs = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h010; cmd_wdata = 32'h12345678; cmd_wstrb = 4'h3;
    rsp_ready = 1;
    exp_q.push_back({1'b1, 32'h0, 2'b10});
    step();
    cmd_valid = 0;
    for (int k = 1; k <= 7; k++) begin
      awready = (k == 1);
      wready  = (k == 5);
      bvalid  = (k == 6);
      bresp   = 2'b10;
      vecs++;
      if ({awvalid, wvalid, bready, rsp_valid} !== {k == 1, k <= 5, k == 6, k == 7}) begin
        errs++;
        $display("FAIL skew_k%0d: got aw=%b w=%b b=%b rv=%b, required %b %b %b %b", k,
                 awvalid, wvalid, bready, rsp_valid, k == 1, k <= 5, k == 6, k == 7);
      end
      if (wvalid && (wdata !== 32'h12345678 || wstrb !== 4'h3)) begin
        vecs++; errs++;
        $display("FAIL skew_wdata_k%0d: got %h/%h, required 12345678/3", k, wdata, wstrb);
      end
      if (awvalid && awready) aw_hs++;
      if (wvalid && wready) w_hs++;
      step();
    end
    bvalid = 0; wready = 0; awready = 0;
    vecs++;
    if (aw_hs !== 1 || w_hs !== 1) begin
      errs++;
      $display("FAIL skew_hs_count: got aw=%0d w=%0d, required 1 1", aw_hs, w_hs);
    end
    vecs++;
    if (cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL skew_done: got cmd_ready=%b, required 1", cmd_ready);
    end
  endtask

  task automatic test_read_stall();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h004; rsp_ready = 0; arready = 1;
    exp_q.push_back({1'b0, 32'h00010203, 2'b10});
    step();
    cmd_valid = 0;
    vecs++;
    if (arvalid !== 1'b1 || araddr !== 12'h004) begin
      errs++;
      $display("FAIL read_ar: got arvalid=%b araddr=%h, required 1 004", arvalid, araddr);
    end
    step();
    arready = 0;
    for (int k = 2; k <= 4; k++) begin
      rvalid = (k == 4); rdata = 32'h00010203; rresp = 2'b10;
      vecs++;
      if ({arvalid, rready, rsp_valid} !== 3'b010) begin
        errs++;
        $display("FAIL read_wait_k%0d: got ar=%b rr=%b rv=%b, required 0 1 0", k, arvalid, rready, rsp_valid);
      end
      step();
    end
    rvalid = 0; rdata = 32'hFFFFFFFF; rresp = 2'b00;
    for (int k = 5; k <= 9; k++) begin
      rsp_ready = (k == 9);
      vecs++;
      if ({rsp_valid, rsp_write, rsp_rdata, rsp_resp, cmd_ready, rready} !== {2'b10, 32'h00010203, 2'b10, 2'b00}) begin
        errs++;
        $display("FAIL read_hold_k%0d: got rv=%b w=%b d=%h r=%b cr=%b rr=%b, required 1 0 00010203 10 0 0",
                 k, rsp_valid, rsp_write, rsp_rdata, rsp_resp, cmd_ready, rready);
      end
      step();
    end
    vecs++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL read_done: got cr=%b rv=%b, required 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit acc1 = 0;
    bit acc2 = 0;
    int a2 = -1;
    int first_ar = -1;
    awready = 1; wready = 1; arready = 1; rsp_ready = 1;
    for (int k = 0; k <= 9; k++) begin
      bvalid = bready; bresp = 2'b00;
      rvalid = rready; rdata = 32'hCAFE0001; rresp = 2'b00;
      if (!acc1) begin
        cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h00C; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
      end else if (!acc2) begin
        cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h020;
      end else begin
        cmd_valid = 0;
      end
      if (cmd_valid && cmd_ready) begin
        if (!acc1) begin
          acc1 = 1; exp_q.push_back({1'b1, 32'h0, 2'b00});
        end else begin
          acc2 = 1; a2 = k; exp_q.push_back({1'b0, 32'hCAFE0001, 2'b00});
        end
      end
      if (arvalid && first_ar < 0) first_ar = k;
      if (((awvalid || wvalid || bready) && (arvalid || rready)) || (cmd_ready && rsp_valid)) begin
        vecs++; errs++;
        $display("FAIL b2b_overlap_k%0d: got aw=%b w=%b b=%b ar=%b r=%b cr=%b rv=%b, required no overlap",
                 k, awvalid, wvalid, bready, arvalid, rready, cmd_ready, rsp_valid);
      end
      step();
    end
    bvalid = 0; rvalid = 0; awready = 0; wready = 0; arready = 0;
    vecs++;
    if (a2 !== 4 || first_ar !== 5) begin
      errs++;
      $display("FAIL b2b_timing: got second accept=%0d first ARVALID=%0d, required 4 5", a2, first_ar);
    end
    vecs++;
    if (exp_q.size() !== 0) begin
      errs++;
      $display("FAIL b2b_drain: got %0d pending responses, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h030; rsp_ready = 1; arready = 0;
    exp_q.push_back({1'b0, 32'h11223344, 2'b00});
    step();
    cmd_valid = 0;
    for (int k = 1; k <= 20; k++) begin
      vecs++;
      if (arvalid !== 1'b1 || timeout !== (k >= 17)) begin
        errs++;
        $display("FAIL timeout_k%0d: got arvalid=%b timeout=%b, required 1 %b", k, arvalid, timeout, k >= 17);
      end
      step();
    end
    arready = 1;
    step();
    arready = 0; rvalid = 1; rdata = 32'h11223344; rresp = 2'b00;
    vecs++;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      errs++;
      $display("FAIL timeout_rdata: got rready=%b arvalid=%b, required 1 0", rready, arvalid);
    end
    step();
    rvalid = 0;
    step();
    vecs++;
    if (cmd_ready !== 1'b1 || timeout !== 1'b1 || exp_q.size() !== 0) begin
      errs++;
      $display("FAIL timeout_sticky: got cr=%b timeout=%b pending=%0d, required 1 1 0", cmd_ready, timeout, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    awready = 1; wready = 1; rsp_ready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h044; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hC;
    step();
    cmd_valid = 0;
    step();
    vecs++;
    if (bready !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_wresp: got bready=%b, required 1", bready);
    end
    #2 rst_n = 0;
    #1;
    vecs++;
    if ({bready, awvalid, wvalid, rsp_valid, cmd_ready, busy, timeout} !== 7'b0) begin
      errs++;
      $display("FAIL rstmid_async: got b=%b aw=%b w=%b rv=%b cr=%b busy=%b to=%b, required all 0",
               bready, awvalid, wvalid, rsp_valid, cmd_ready, busy, timeout);
    end
    step();
    rst_n = 1;
    step();
    vecs++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_release: got cr=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h048; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF;
    exp_q.push_back({1'b1, 32'h0, 2'b01});
    step();
    cmd_valid = 0;
    while (!(rsp_valid && rsp_ready) && n < 10) begin
      bvalid = bready; bresp = 2'b01;
      step();
      n++;
    end
    bvalid = 0;
    vecs++;
    if (n >= 10) begin
      errs++;
      $display("FAIL rstmid_fresh_timeout: got no response in %0d cycles, required response", n);
    end
    step();
    vecs++;
    if (exp_q.size() !== 0 || cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_fresh_done: got pending=%0d cr=%b, required 0 1", exp_q.size(), cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_skewed_write();
    test_read_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
